uart_tx: RTL and testbench

- Byte-wide UART transmitter; the transmit counterpart of the SoC's UART receive path.
- Accepts bytes from the bus-side register write strobe into a small FIFO and serialises them onto TXD as 8N1/8N2 frames, LSB first.
- Shares the baud generator protocol with the receiver:
  - requests ticks via bps_en;
  - consumes one-cycle clk_uart pulses.
- Raises a one-cycle interrupt at each frame completion.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and line idle level.
// Imported by the transmitter and intended for reuse by the receive path.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic TXD_IDLE       = 1'b1;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock FIFO with registered count; pop_data shows the head combinationally, 1-cycle push-to-visible.
// Writes while full are dropped (full sampled before any same-cycle pop) and flagged by a 1-cycle overflow pulse.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter fed by a byte FIFO; first START bit on TXD two cycles after wr_en into an idle block.
// No backpressure to the writer: writes while the FIFO is full are dropped and reported on overflow.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       clk_uart,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       TXD,
    output logic       bps_en,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       busy,
    output logic       overflow,
    output logic       interrupt
);

    localparam logic [1:0] IDLE  = UART_IDLE;
    localparam logic [1:0] START = UART_START;
    localparam logic [1:0] DATA  = UART_DATA;
    localparam logic [1:0] STOP  = UART_STOP;

    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] shift_nxt;
    logic [UART_DATA_BITS-1:0] pop_data;
    logic                      pop;
    logic                      frame_done;
    logic                      txd_nxt;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .RSTn      (RSTn),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (clk_uart) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (clk_uart && bit_cnt == LAST_DATA) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next START so queued bytes leave no idle gap.
                if (clk_uart && bit_cnt == LAST_STOP) begin
                    frame_done = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_nxt = shift_reg;
        if (pop) begin
            shift_nxt = pop_data;
        end else if (state == DATA && clk_uart) begin
            shift_nxt = {1'b1, shift_reg[UART_DATA_BITS-1:1]};
        end
    end

    always_comb begin
        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shift_nxt[0];
            default: txd_nxt = TXD_IDLE;
        endcase
    end

    // bps_en holds for one extra cycle after returning to IDLE.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '1;
            TXD       <= TXD_IDLE;
            bps_en    <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            TXD       <= txd_nxt;
            bps_en    <= (state_nxt != IDLE) || (state != IDLE);
            interrupt <= frame_done;
            if (frame_done || (state == START && clk_uart)) begin
                bit_cnt <= '0;
            end else if ((state == DATA || state == STOP) && clk_uart) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    assign busy = bps_en;

endmodule

// File: tb/tb_uart_tx.sv
// Two transmitters (1 and 2 stop bits) driven by the same writes, checked every cycle against a frame-level model.
module tb_uart_tx;

    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = 16;

    logic       clk;
    logic       RSTn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       force_tick;
    logic [1:0] tick;
    logic [1:0] txd, bps, full, empty, busy, ovf, intr;
    int         bcnt [2];

    int total;
    int bad;
    int icnt [2];

    // model state
    logic [7:0]  mq     [2][FIFO_DEPTH];
    int          mhead  [2];
    int          mcnt   [2];
    int          mpos   [2];
    bit          mact   [2];
    logic [10:0] mframe [2];
    bit          e_txd  [2];
    bit          e_bps  [2];
    bit          e_int  [2];
    bit          e_ovf  [2];

    uart_tx #(.FIFO_DEPTH(FIFO_DEPTH), .STOP_BITS(1)) u0 (
        .clk(clk), .RSTn(RSTn), .clk_uart(tick[0]), .wr_en(wr_en), .wr_data(wr_data),
        .TXD(txd[0]), .bps_en(bps[0]), .fifo_full(full[0]), .fifo_empty(empty[0]),
        .busy(busy[0]), .overflow(ovf[0]), .interrupt(intr[0])
    );

    uart_tx #(.FIFO_DEPTH(FIFO_DEPTH), .STOP_BITS(2)) u1 (
        .clk(clk), .RSTn(RSTn), .clk_uart(tick[1]), .wr_en(wr_en), .wr_data(wr_data),
        .TXD(txd[1]), .bps_en(bps[1]), .fifo_full(full[1]), .fifo_empty(empty[1]),
        .busy(busy[1]), .overflow(ovf[1]), .interrupt(intr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // baud generator: counts only while enabled, one pulse per DIV cycles
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bcnt[i] <= bps[i] ? ((bcnt[i] == DIV - 1) ? 0 : bcnt[i] + 1) : 0;
        end
    end
    assign tick[0] = force_tick | (bps[0] && bcnt[0] == DIV - 1);
    assign tick[1] = force_tick | (bps[1] && bcnt[1] == DIV - 1);

    task automatic chk(input string name, input int i, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%b want=%b", name, i, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mhead[i] = 0;
            mcnt[i]  = 0;
            mpos[i]  = 0;
            mact[i]  = 1'b0;
            e_txd[i] = 1'b1;
            e_bps[i] = 1'b0;
            e_int[i] = 1'b0;
            e_ovf[i] = 1'b0;
        end
    endtask

    // One clock edge of the model: frame bit positions, queue, and line level.
    task automatic model_update();
        int n;
        bit was_act;
        if (!RSTn) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            n        = mcnt[i];
            was_act  = mact[i];
            e_int[i] = 1'b0;
            if (mact[i] && tick[i]) begin
                mpos[i]++;
                if (mpos[i] == 10 + i) begin
                    e_int[i] = 1'b1;
                    mact[i]  = 1'b0;
                end
            end
            if (!mact[i] && n > 0) begin
                mframe[i] = {2'b11, mq[i][mhead[i]], 1'b0};
                mhead[i]  = (mhead[i] + 1) % FIFO_DEPTH;
                mcnt[i]--;
                mact[i]   = 1'b1;
                mpos[i]   = 0;
            end
            e_ovf[i] = wr_en && (n == FIFO_DEPTH);
            if (wr_en && n < FIFO_DEPTH) begin
                mq[i][(mhead[i] + mcnt[i]) % FIFO_DEPTH] = wr_data;
                mcnt[i]++;
            end
            e_txd[i] = mact[i] ? mframe[i][mpos[i]] : 1'b1;
            e_bps[i] = mact[i] || was_act;
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            chk("txd",        i, txd[i],   e_txd[i]);
            chk("bps_en",     i, bps[i],   e_bps[i]);
            chk("busy",       i, busy[i],  e_bps[i]);
            chk("interrupt",  i, intr[i],  e_int[i]);
            chk("overflow",   i, ovf[i],   e_ovf[i]);
            chk("fifo_empty", i, empty[i], mcnt[i] == 0);
            chk("fifo_full",  i, full[i],  mcnt[i] == FIFO_DEPTH);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
        for (int i = 0; i < 2; i++) icnt[i] += int'(intr[i]);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (!(empty == 2'b11 && busy == 2'b00) && n < max) begin
            step();
            n++;
        end
        chk("drain_timeout", 0, n < max, 1'b1);
    endtask

    initial begin
        int a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int i0, i1, gaps;
        total      = 0;
        bad        = 0;
        icnt[0]    = 0;
        icnt[1]    = 0;
        RSTn       = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        force_tick = 1'b0;
        model_reset();
        steps(3);
        for (int i = 0; i < 2; i++) begin
            chk("rst_txd",   i, txd[i],   1'b1);
            chk("rst_bps",   i, bps[i],   1'b0);
            chk("rst_empty", i, empty[i], 1'b1);
            chk("rst_full",  i, full[i],  1'b0);
        end
        RSTn = 1'b1;
        steps(2);

        // single byte A5 with literal bit timing
        i0 = icnt[0];
        write(8'hA5);
        chk("a5_n1_txd",   0, txd[0],   1'b1);
        chk("a5_n1_empty", 0, empty[0], 1'b0);
        step();
        chk("a5_n2_txd", 0, txd[0], 1'b0);
        chk("a5_n2_bps", 0, bps[0], 1'b1);
        steps(8);
        for (int k = 0; k < 8; k++) begin
            steps(16);
            chk("a5_bit", 0, txd[0], a5_bits[k][0]);
            chk("a5_bit", 1, txd[1], a5_bits[k][0]);
        end
        steps(16);
        chk("a5_stop", 0, txd[0], 1'b1);
        steps(8);
        chk("a5_int",     0, intr[0], 1'b1);
        chk("a5_int_bps", 0, bps[0],  1'b1);
        chk("a5_sb2_int_early", 1, intr[1], 1'b0);
        step();
        chk("a5_bps_fall", 0, bps[0],  1'b0);
        chk("a5_int_end",  0, intr[0], 1'b0);
        steps(15);
        chk("a5_sb2_int", 1, intr[1], 1'b1);
        step();
        chk("a5_sb2_bps_fall", 1, bps[1], 1'b0);
        chk("a5_int_count", 0, icnt[0] == i0 + 1, 1'b1);
        steps(4);

        // three back-to-back frames
        i0 = icnt[0];
        i1 = icnt[1];
        write(8'h00);
        write(8'hFF);
        write(8'h3C);
        gaps = 0;
        for (int n = 0; n < 2000 && icnt[1] < i1 + 3; n++) begin
            step();
            if (icnt[0] < i0 + 3 && bps[0] == 1'b0) gaps++;
        end
        chk("b2b_bps_gap", 0, gaps == 0, 1'b1);
        wait_idle(2000);
        chk("b2b_int_count", 0, icnt[0] == i0 + 3, 1'b1);
        chk("b2b_int_count", 1, icnt[1] == i1 + 3, 1'b1);

        // overflow: five writes while one frame is in flight
        i0 = icnt[0];
        write(8'h11);
        steps(5);
        write(8'h22);
        write(8'h33);
        write(8'h44);
        write(8'h55);
        chk("ovf_full", 0, full[0], 1'b1);
        chk("ovf_full", 1, full[1], 1'b1);
        write(8'h66);
        chk("ovf_pulse", 0, ovf[0], 1'b1);
        chk("ovf_pulse", 1, ovf[1], 1'b1);
        step();
        chk("ovf_end", 0, ovf[0], 1'b0);
        wait_idle(4000);
        chk("ovf_frames", 0, icnt[0] == i0 + 5, 1'b1);

        // reset in the middle of DATA with two bytes queued
        write(8'h55);
        write(8'h0F);
        write(8'hF0);
        steps(40);
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("mid_rst_txd",   i, txd[i],   1'b1);
            chk("mid_rst_bps",   i, bps[i],   1'b0);
            chk("mid_rst_empty", i, empty[i], 1'b1);
        end
        steps(2);
        RSTn = 1'b1;
        i0 = icnt[0];
        i1 = icnt[1];
        steps(400);
        chk("mid_rst_no_int", 0, icnt[0] == i0, 1'b1);
        chk("mid_rst_no_int", 1, icnt[1] == i1, 1'b1);

        // baud ticks while idle do nothing
        force_tick = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            chk("idle_tick_txd", 0, txd[0], 1'b1);
            chk("idle_tick_bps", 1, bps[1], 1'b0);
        end
        force_tick = 1'b0;
        chk("idle_tick_no_int", 0, icnt[0] == i0, 1'b1);

        // random bytes with random spacing; overflows are expected and modelled
        for (int n = 0; n < 40; n++) begin
            steps($urandom_range(0, 60));
            write(8'($urandom_range(0, 255)));
        end
        step();
        wait_idle(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
